// File: rtl/clock_period_meter.sv
// Measures the spacing between rising edges of i_signal in i_clock cycles and reports period, lock and timeout.
// Optional input synchroniser is built when CLOCK_PERIOD_METER_SYNC_EN is defined.
module clock_period_meter #(
    parameter int max_counter = 256,
    parameter int lock_count  = 4,
    localparam int BITS = (max_counter <= 2) ? 1 :
                          (($clog2(max_counter) > 30) ? 30 : $clog2(max_counter))
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_signal,
    output logic [BITS-1:0] o_period,
    output logic            o_valid,
    output logic            o_locked,
    output logic            o_overflow
);

    localparam int RW = $clog2(lock_count + 1);
    localparam logic [BITS-1:0] CNT_MAX = {BITS{1'b1}};
    localparam logic [BITS-1:0] CNT_ONE = BITS'(1);
    localparam logic [RW-1:0]   RUN_LOCK = RW'(lock_count);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] TIMEOUT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [BITS-1:0] cnt_q, cnt_d;
    logic [BITS-1:0] period_q, period_d;
    logic            valid_q, valid_d;
    logic            locked_q, locked_d;
    logic            ovf_q, ovf_d;
    logic [RW-1:0]   run_q, run_d;
    logic            s_prev_q;
    logic            sig_s;
    logic            edge_s;

`ifdef CLOCK_PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser for an asynchronous tick stream
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_signal};
        end
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = i_signal;
`endif

    assign edge_s = sig_s & ~s_prev_q;

    // Next-state logic: spacing counter, FSM, report and lock tracking
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + BITS'(1);
        period_d = period_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        ovf_d    = ovf_q;
        run_d    = run_q;
        case (state_q)
            IDLE: begin
                if (edge_s) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            MEASURE: begin
                if (edge_s) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    ovf_d    = 1'b0;
                    cnt_d    = CNT_ONE;
                    // run of zero marks the first report after arming or a timeout
                    if (run_q == RW'(0) || cnt_q != period_q) begin
                        run_d = RW'(1);
                    end else if (run_q < RUN_LOCK) begin
                        run_d = run_q + RW'(1);
                    end else begin
                        run_d = run_q;
                    end
                    locked_d = (run_d >= RUN_LOCK);
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = TIMEOUT;
                    ovf_d    = 1'b1;
                    locked_d = 1'b0;
                    run_d    = RW'(0);
                end else begin
                    state_d = MEASURE;
                end
            end
            TIMEOUT: begin
                if (edge_s) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = TIMEOUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ONE;
            period_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
            run_q    <= '0;
            s_prev_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
            run_q    <= run_d;
            s_prev_q <= sig_s;
        end
    end

    assign o_period   = period_q;
    assign o_valid    = valid_q;
    assign o_locked   = locked_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized bench for clock_period_meter (max_counter=16) against an edge-spacing reference model.
module tb_clock_period_meter;

    localparam int MAXC  = 16;
    localparam int CMAX  = 15;
    localparam int LOCKN = 4;

    logic       clk;
    logic       i_reset;
    logic       i_signal;
    logic [3:0] o_period;
    logic       o_valid;
    logic       o_locked;
    logic       o_overflow;

    int err_cnt = 0;
    int chk_cnt = 0;

    // reference model state (edge-spacing view)
    int   it;
    bit   armed, tout, m_valid, m_locked, m_ovf, vprev;
    int   last_edge, m_period, m_run;
    bit [1:0] pipe;

    clock_period_meter #(.max_counter(MAXC), .lock_count(LOCKN)) dut (
        .i_clock   (clk),
        .i_reset   (i_reset),
        .i_signal  (i_signal),
        .o_period  (o_period),
        .o_valid   (o_valid),
        .o_locked  (o_locked),
        .o_overflow(o_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s at iter %0d: got %0d expected %0d", tag, it, got, exp);
        end
    endtask

    task automatic model_reset();
        armed = 0; tout = 0; m_valid = 0; m_locked = 0; m_ovf = 0;
        vprev = 0; last_edge = 0; m_period = 0; m_run = 0; pipe = 2'b00;
    endtask

    task automatic model_tick(input bit v);
        bit s, e;
        int el;
`ifdef CLOCK_PERIOD_METER_SYNC_EN
        s = pipe[1];
        pipe = {pipe[0], v};
`else
        s = v;
`endif
        e = s & ~vprev;
        vprev = s;
        m_valid = 0;
        if (!armed) begin
            if (e) begin armed = 1; last_edge = it; end
        end else if (tout) begin
            if (e) begin tout = 0; last_edge = it; end
        end else begin
            el = it - last_edge;
            if (e) begin
                m_valid = 1;
                m_ovf = 0;
                if (m_run == 0 || el != m_period) m_run = 1;
                else if (m_run < LOCKN) m_run = m_run + 1;
                m_period = el;
                m_locked = (m_run >= LOCKN);
                last_edge = it;
            end else if (el >= CMAX) begin
                tout = 1; m_ovf = 1; m_locked = 0; m_run = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("valid", int'(o_valid), int'(m_valid));
        check_eq("period", int'(o_period), m_period);
        check_eq("locked", int'(o_locked), int'(m_locked));
        check_eq("overflow", int'(o_overflow), int'(m_ovf));
    endtask

    task automatic step(input logic v);
        i_signal = v;
        @(posedge clk);
        #1;
        it++;
        if (i_reset) model_reset();
        else model_tick(v);
        check_outputs();
    endtask

    // one spacing of n cycles: high for h, low for the rest
    task automatic pulse(input int n, input int h);
        for (int k = 0; k < n; k++) step(k < h);
    endtask

    task automatic pulse_rand(input int n);
        pulse(n, (n < 2) ? 1 : int'($urandom_range(n - 1, 1)));
    endtask

    initial begin
        int n;
        it = 0;
        model_reset();
        i_signal = 1'b0;
        i_reset  = 1'b1;
        #2;
        check_outputs();
        @(posedge clk); #1;
        i_reset = 1'b0;

        // divider-like stream of period 5, then a 7, then relock
        for (int r = 0; r < 6; r++) pulse(5, 2);
        pulse(7, 3);
        for (int r = 0; r < 6; r++) pulse(5, 3);
        // tie at maximum count, then just over it, then a long low hold
        pulse(15, 1);
        pulse(15, 7);
        pulse(16, 1);
        pulse(20, 1);
        pulse(4, 1);
        pulse(4, 1);
        // held high leads to timeout
        pulse(25, 24);
        pulse(6, 3);
        pulse(6, 3);

        // reset midway through a 6-cycle spacing
        pulse(6, 2);
        step(1'b1); step(1'b0); step(1'b0);
        i_reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        step(1'b0);
        step(1'b0);
        i_reset = 1'b0;
        for (int r = 0; r < 4; r++) pulse(6, 2);

        // randomized segments: repeated runs, random spacings and long holds
        for (int seg = 0; seg < 120; seg++) begin
            case ($urandom_range(3, 0))
                0: begin
                    n = $urandom_range(16, 2);
                    for (int r = 0; r < int'($urandom_range(7, 3)); r++) pulse_rand(n);
                end
                1: pulse_rand($urandom_range(22, 2));
                2: pulse($urandom_range(30, 14), 1);
                default: pulse_rand($urandom_range(6, 2));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
